seq_multiplier_n: RTL and testbench

- Parametrised N-bit sequential shift-add multiplier; next generation of the team's 8-bit unsigned multiplier.
- Adds a runtime signed mode: two's-complement radix-2 Booth recoding.
- Adds a one-cycle done pulse and a held result register.
- Sits beside the existing datapath blocks; a controller drives it with a start/ready handshake.

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_multiplier_n_if.sv | 27 ++
 rtl/seq_mult_addsub.sv | 33 +++
 rtl/seq_multiplier_n.sv | 108 ++++++++++
 tb/tb_seq_multiplier_n.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_mult_pkg : shared FSM state and Booth operation encodings        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package seq_mult_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_t;

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_n_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_multiplier_n_if : start/ready handshake and product bus          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface seq_multiplier_n_if #(
  parameter int N = 8
);
  logic             start;
  logic             signed_mode;
  logic [N-1:0]     Min;
  logic [N-1:0]     Qin;
  logic             ready;
  logic             done;
  logic [2*N-1:0]   AQ;

  modport master (
    output start, signed_mode, Min, Qin,
    input  ready, done, AQ
  );

  modport slave (
    input  start, signed_mode, Min, Qin,
    output ready, done, AQ
  );
endinterface
`default_nettype wire

// File: rtl/seq_mult_addsub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_mult_addsub : (N+1)-bit accumulator add/subtract of extended M   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module seq_mult_addsub
  import seq_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] m,
  input  op_t          op,
  input  logic         mode,
  output logic [N:0]   y
);

  logic [N:0] w_m_ext;

  // Signed mode sign-extends M; unsigned mode zero-extends so the carry lands in bit N.
  assign w_m_ext = mode ? {m[N-1], m} : {1'b0, m};

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + w_m_ext;
      OP_SUB:  y = a - w_m_ext;
      default: y = a;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_multiplier_n : N-bit sequential shift-add / radix-2 Booth mult   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module seq_multiplier_n
  import seq_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clock,
  input  logic               reset,
  seq_multiplier_n_if.slave  bus
);

  localparam int c_CNT_W = $clog2(N + 1);

  state_t             r_state;
  logic [N:0]         r_a;
  logic [N-1:0]       r_q;
  logic [N-1:0]       r_m;
  logic               r_q1;
  logic               r_mode;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_ready;
  logic               r_done;
  logic [2*N-1:0]     r_aq;

  op_t                w_op;
  logic [N:0]         w_sum;
  logic [N:0]         w_a_sh;
  logic [N-1:0]       w_q_sh;

  always_comb begin
    w_op = OP_NONE;
    if (r_mode) begin
      case ({r_q[0], r_q1})
        2'b01:   w_op = OP_ADD;
        2'b10:   w_op = OP_SUB;
        default: w_op = OP_NONE;
      endcase
    end else if (r_q[0]) begin
      w_op = OP_ADD;
    end
  end

  seq_mult_addsub #(.N(N)) u_addsub (
    .a    (r_a),
    .m    (r_m),
    .op   (w_op),
    .mode (r_mode),
    .y    (w_sum)
  );

  // Arithmetic shift replicates A[N] in signed mode, logical shift otherwise.
  assign w_a_sh = {r_mode & w_sum[N], w_sum[N:1]};
  assign w_q_sh = {w_sum[0], r_q[N-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_q1    <= 1'b0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_aq    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_m     <= bus.Min;
            r_q     <= bus.Qin;
            r_mode  <= bus.signed_mode;
            r_a     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= c_CNT_W'(N);
            r_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= w_a_sh;
          r_q   <= w_q_sh;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (r_cnt == c_CNT_W'(1)) begin
            r_aq    <= {w_a_sh[N-1:0], w_q_sh};
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.AQ    = r_aq;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_seq_multiplier_n : random and directed checks for N=8, 4, 16      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_seq_multiplier_n;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  seq_multiplier_n_if #(.N(8))  b8();
  seq_multiplier_n_if #(.N(4))  b4();
  seq_multiplier_n_if #(.N(16)) b16();

  seq_multiplier_n #(.N(8))  u8  (.clock(clock), .reset(reset), .bus(b8));
  seq_multiplier_n #(.N(4))  u4  (.clock(clock), .reset(reset), .bus(b4));
  seq_multiplier_n #(.N(16)) u16 (.clock(clock), .reset(reset), .bus(b16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mathematical product of n-bit operands, truncated to 2n bits.
  function automatic longint ref_prod(int n, bit mode, longint m, longint q);
    longint a;
    longint b;
    a = m;
    b = q;
    if (mode && m[n-1]) a = m - (longint'(1) << n);
    if (mode && q[n-1]) b = q - (longint'(1) << n);
    return (a * b) & ((longint'(1) << (2 * n)) - 1);
  endfunction

  task automatic run8(input bit mode, input logic [7:0] m, input logic [7:0] q,
                      output logic [15:0] aq, output int cyc, output int lowcnt);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!b8.ready && guard < 50) begin @(negedge clock); guard++; end
    b8.start = 1'b1; b8.signed_mode = mode; b8.Min = m; b8.Qin = q;
    @(posedge clock); #1;
    b8.start = 1'b0;
    cyc = 0; lowcnt = 0;
    while (!b8.done && cyc < 13) begin
      if (!b8.ready) lowcnt++;
      @(posedge clock); #1;
      cyc++;
    end
    aq = b8.AQ;
  endtask

  task automatic run4(input bit mode, input logic [3:0] m, input logic [3:0] q,
                      output logic [7:0] aq, output int cyc);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!b4.ready && guard < 50) begin @(negedge clock); guard++; end
    b4.start = 1'b1; b4.signed_mode = mode; b4.Min = m; b4.Qin = q;
    @(posedge clock); #1;
    b4.start = 1'b0;
    cyc = 0;
    while (!b4.done && cyc < 9) begin @(posedge clock); #1; cyc++; end
    aq = b4.AQ;
  endtask

  task automatic run16(input bit mode, input logic [15:0] m, input logic [15:0] q,
                       output logic [31:0] aq, output int cyc);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!b16.ready && guard < 50) begin @(negedge clock); guard++; end
    b16.start = 1'b1; b16.signed_mode = mode; b16.Min = m; b16.Qin = q;
    @(posedge clock); #1;
    b16.start = 1'b0;
    cyc = 0;
    while (!b16.done && cyc < 21) begin @(posedge clock); #1; cyc++; end
    aq = b16.AQ;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (b8.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", b8.ready); end
    checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", b8.done); end
    checks++; if (b8.AQ !== 16'h0) begin errors++; $display("FAIL reset_aq got %h want 0000", b8.AQ); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_unsigned_max();
    logic [15:0] aq;
    int cyc, low;
    run8(1'b0, 8'd255, 8'd255, aq, cyc, low);
    checks++; if (aq !== 16'hFE01) begin errors++; $display("FAIL umax_aq got %h want fe01", aq); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL umax_latency got %0d want 8", cyc); end
    checks++; if (low !== 8) begin errors++; $display("FAIL umax_ready_low got %0d want 8", low); end
    checks++; if (b8.ready !== 1'b1) begin errors++; $display("FAIL umax_ready_on_done got %b want 1", b8.ready); end
    @(posedge clock); #1;
    checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL umax_done_width got %b want 0", b8.done); end
  endtask

  task automatic test_signed();
    logic [15:0] aq;
    int cyc, low;
    run8(1'b1, 8'h80, 8'h80, aq, cyc, low);
    checks++; if (aq !== 16'h4000) begin errors++; $display("FAIL s_min_min got %h want 4000", aq); end
    run8(1'b1, 8'hFD, 8'h05, aq, cyc, low);
    checks++; if (aq !== 16'hFFF1) begin errors++; $display("FAIL s_m3_5 got %h want fff1", aq); end
    run8(1'b1, 8'h7F, 8'h80, aq, cyc, low);
    checks++; if (aq !== 16'hC080) begin errors++; $display("FAIL s_127_m128 got %h want c080", aq); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL s_latency got %0d want 8", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clock);
    b8.start = 1'b1; b8.signed_mode = 1'b0; b8.Min = 8'd3; b8.Qin = 8'd5;
    @(posedge clock); #1;
    b8.Min = 8'd1; b8.Qin = 8'd1; b8.signed_mode = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    checks++; if (b8.AQ !== 16'hC080) begin errors++; $display("FAIL hold_aq_during_run got %h want c080", b8.AQ); end
    cyc = 3;
    while (!b8.done && cyc < 13) begin @(posedge clock); #1; cyc++; end
    checks++; if (b8.AQ !== 16'd15) begin errors++; $display("FAIL ignore_start got %h want 000f", b8.AQ); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", cyc); end
    b8.signed_mode = 1'b0; b8.Min = 8'd7; b8.Qin = 8'd9;
    @(posedge clock); #1;
    b8.start = 1'b0;
    checks++; if (b8.ready !== 1'b0 || b8.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got ready=%b done=%b want 0 0", b8.ready, b8.done);
    end
    cyc = 0;
    while (!b8.done && cyc < 13) begin @(posedge clock); #1; cyc++; end
    checks++; if (b8.AQ !== 16'd63) begin errors++; $display("FAIL b2b_aq got %h want 003f", b8.AQ); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL b2b_latency got %0d want 8", cyc); end
  endtask

  task automatic test_async_reset();
    logic [15:0] aq;
    int cyc, low;
    @(negedge clock);
    b8.start = 1'b1; b8.signed_mode = 1'b0; b8.Min = 8'd200; b8.Qin = 8'd3;
    @(posedge clock); #1;
    b8.start = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (b8.AQ !== 16'h0) begin errors++; $display("FAIL areset_aq got %h want 0000", b8.AQ); end
    checks++; if (b8.ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", b8.ready); end
    checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL areset_done got %b want 0", b8.done); end
    @(negedge clock); #1;
    reset = 1'b0;
    run8(1'b0, 8'd6, 8'd7, aq, cyc, low);
    checks++; if (aq !== 16'd42) begin errors++; $display("FAIL areset_rerun got %h want 002a", aq); end
  endtask

  task automatic test_zero();
    logic [15:0] aq;
    int cyc, low;
    logic [7:0] ms [4];
    logic [7:0] qs [4];
    ms = '{8'h00, 8'hA5, 8'h00, 8'h81};
    qs = '{8'hC3, 8'h00, 8'h7F, 8'h00};
    for (int i = 0; i < 4; i++) begin
      run8(i[1], ms[i], qs[i], aq, cyc, low);
      checks++; if (aq !== 16'h0 || cyc !== 8) begin
        errors++; $display("FAIL zero_%0d got aq=%h cyc=%0d want 0000 8", i, aq, cyc);
      end
    end
  endtask

  task automatic test_sweep4();
    logic [7:0] aq;
    logic [7:0] exp;
    logic [3:0] m, q;
    bit mode;
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      m = 4'($urandom); q = 4'($urandom); mode = 1'($urandom);
      exp = 8'(ref_prod(4, mode, longint'(m), longint'(q)));
      run4(mode, m, q, aq, cyc);
      checks++; if (aq !== exp || cyc !== 4) begin
        errors++; $display("FAIL sweep4 m=%h q=%h s=%b got %h cyc=%0d want %h cyc=4", m, q, mode, aq, cyc, exp);
      end
      @(posedge clock); #1;
      checks++; if (b4.done !== 1'b0) begin errors++; $display("FAIL sweep4_done_width got %b want 0", b4.done); end
    end
  endtask

  task automatic test_sweep16();
    logic [31:0] aq;
    logic [31:0] exp;
    logic [15:0] m, q;
    bit mode;
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      m = 16'($urandom); q = 16'($urandom); mode = 1'($urandom);
      if (i < 4) begin m = (i[0]) ? 16'h8000 : 16'hFFFF; q = (i[1]) ? 16'h8000 : 16'hFFFF; end
      exp = 32'(ref_prod(16, mode, longint'(m), longint'(q)));
      run16(mode, m, q, aq, cyc);
      checks++; if (aq !== exp || cyc !== 16) begin
        errors++; $display("FAIL sweep16 m=%h q=%h s=%b got %h cyc=%0d want %h cyc=16", m, q, mode, aq, cyc, exp);
      end
      @(posedge clock); #1;
      checks++; if (b16.done !== 1'b0) begin errors++; $display("FAIL sweep16_done_width got %b want 0", b16.done); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    b8.start = 1'b0;  b8.signed_mode = 1'b0;  b8.Min = '0;  b8.Qin = '0;
    b4.start = 1'b0;  b4.signed_mode = 1'b0;  b4.Min = '0;  b4.Qin = '0;
    b16.start = 1'b0; b16.signed_mode = 1'b0; b16.Min = '0; b16.Qin = '0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_async_reset();
    test_zero();
    test_sweep4();
    test_sweep16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
